decode_ctrl_stage: RTL and testbench

- Next-generation RV32 control decoder. Fuses main and ALU decode, checks for illegal instructions, and registers all controls into the ID/EX boundary.
- Stall and flush handling are built in.
- Optional M-extension decode (parameter); divide ops hold the E stage for a fixed multi-cycle latency via an internal counter.
- Sits between the instruction register in D and the execute datapath; the hazard unit consumes md_busy.

---
 rtl/decode_ctrl_pkg.sv | 88 ++++++++
 rtl/decode_ctrl_comb.sv | 150 +++++++++++++++
 rtl/decode_ctrl_stage.sv | 121 ++++++++++++
 tb/tb_decode_ctrl_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared constants and types for the RV32 decode/control stage.
// Holds opcode values, funct7 qualifiers, imm_src / result_src / alu_ctrl
// codes, the packed control bundle carried into E, and the divide FSM states.
package decode_ctrl_pkg;

   // Major opcodes handled by the decoder
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // funct7 qualifiers
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // Immediate format select
   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_S     = 3'b001;
   localparam logic [2:0] IMM_B     = 3'b010;
   localparam logic [2:0] IMM_J     = 3'b011;
   localparam logic [2:0] IMM_AUIPC = 3'b100;
   localparam logic [2:0] IMM_LUI   = 3'b101;

   // Writeback result select
   localparam logic [1:0] RES_ALU   = 2'b00;
   localparam logic [1:0] RES_MEM   = 2'b01;
   localparam logic [1:0] RES_PC4   = 2'b10;
   localparam logic [1:0] RES_UPPER = 2'b11;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_AND    = 4'b0010;
   localparam logic [3:0] ALU_OR     = 4'b0011;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_SLT    = 4'b0101;
   localparam logic [3:0] ALU_SLTU   = 4'b0110;
   localparam logic [3:0] ALU_SLL    = 4'b0111;
   localparam logic [3:0] ALU_SRL    = 4'b1000;
   localparam logic [3:0] ALU_SRA    = 4'b1001;
   localparam logic [3:0] ALU_MUL    = 4'b1010;
   localparam logic [3:0] ALU_MULH   = 4'b1011;
   localparam logic [3:0] ALU_MULHSU = 4'b1100;
   localparam logic [3:0] ALU_MULHU  = 4'b1101;
   localparam logic [3:0] ALU_DIV    = 4'b1110;
   localparam logic [3:0] ALU_PASSB  = 4'b1111;

   // Control bundle registered into E; all-zero is a bubble.
   typedef struct packed {
      logic       reg_write;
      logic [2:0] imm_src;
      logic       alu_src;
      logic       mem_write;
      logic [1:0] result_src;
      logic [3:0] alu_ctrl;
      logic       jump;
      logic       jalr;
      logic       branch;
      logic [2:0] funct3;
      logic       illegal;
   } ctrl_t;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_state_t;

   // funct3 -> ALU op for the shared R/I integer group (funct7 = 0000000).
   function automatic logic [3:0] base_alu_op(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Pure combinational RV32 control decoder with illegal-instruction check.
// Ports:
//   instr   - 32-bit instruction word
//   ctrl    - decoded control bundle (funct3 raw, illegal flag set on any
//             illegal encoding, side-effecting controls forced 0 then)
//   is_div  - legal DIV/DIVU/REM/REMU (only possible when ENABLE_M = 1)
module decode_ctrl_comb
   import decode_ctrl_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        is_div
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       legal;
   logic       div_raw;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Register specifiers and the low immediate bits belong to the datapath.
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   // NOTE: every output of a combinational block gets a default before any
   // branch, so no path can leave it unassigned and infer a latch.
   always_comb begin
      ctrl        = '0;
      legal       = 1'b1;
      div_raw     = 1'b0;
      ctrl.funct3 = funct3;

      case (opcode)
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.imm_src    = IMM_I;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
            ctrl.alu_ctrl   = ALU_ADD;
            if (funct3 == 3'b011 || funct3[2:1] == 2'b11) legal = 1'b0;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.imm_src   = IMM_S;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_ctrl  = ALU_ADD;
            if (funct3 > 3'b010) legal = 1'b0;
         end
         OP_R: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_ALU;
            case (funct7)
               F7_BASE: ctrl.alu_ctrl = base_alu_op(funct3);
               F7_ALT: begin
                  if (funct3 == 3'b000)      ctrl.alu_ctrl = ALU_SUB;
                  else if (funct3 == 3'b101) ctrl.alu_ctrl = ALU_SRA;
                  else                       legal = 1'b0;
               end
               F7_MULDIV: begin
                  if (ENABLE_M) begin
                     case (funct3)
                        3'b000:  ctrl.alu_ctrl = ALU_MUL;
                        3'b001:  ctrl.alu_ctrl = ALU_MULH;
                        3'b010:  ctrl.alu_ctrl = ALU_MULHSU;
                        3'b011:  ctrl.alu_ctrl = ALU_MULHU;
                        default: begin
                           ctrl.alu_ctrl = ALU_DIV;
                           div_raw       = 1'b1;
                        end
                     endcase
                  end else begin
                     legal = 1'b0;
                  end
               end
               default: legal = 1'b0;
            endcase
         end
         OP_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.imm_src   = IMM_I;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_ctrl  = base_alu_op(funct3);
            // Shift immediates reuse imm[11:5] as a funct7 qualifier.
            if (funct3 == 3'b001 && funct7 != F7_BASE) legal = 1'b0;
            if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)        ctrl.alu_ctrl = ALU_SRA;
               else if (funct7 != F7_BASE) legal = 1'b0;
            end
         end
         OP_BRANCH: begin
            ctrl.branch   = 1'b1;
            ctrl.imm_src  = IMM_B;
            ctrl.alu_ctrl = ALU_SUB;
            if (funct3 == 3'b010 || funct3 == 3'b011) legal = 1'b0;
         end
         OP_AUIPC: begin
            ctrl.reg_write  = 1'b1;
            ctrl.imm_src    = IMM_AUIPC;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_UPPER;
            ctrl.alu_ctrl   = ALU_ADD;
         end
         OP_LUI: begin
            ctrl.reg_write  = 1'b1;
            ctrl.imm_src    = IMM_LUI;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_UPPER;
            ctrl.alu_ctrl   = ALU_PASSB;
         end
         OP_JALR: begin
            ctrl.reg_write  = 1'b1;
            ctrl.imm_src    = IMM_I;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.alu_ctrl   = ALU_ADD;
            ctrl.jalr       = 1'b1;
            if (funct3 != 3'b000) legal = 1'b0;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.imm_src    = IMM_J;
            ctrl.result_src = RES_PC4;
            ctrl.alu_ctrl   = ALU_ADD;
            ctrl.jump       = 1'b1;
         end
         default: legal = 1'b0;
      endcase

      // Compressed / reserved encodings never reach this decoder legally.
      if (instr[1:0] != 2'b11) legal = 1'b0;

      // An illegal instruction must not change architectural state.
      if (!legal) begin
         ctrl.reg_write = 1'b0;
         ctrl.mem_write = 1'b0;
         ctrl.jump      = 1'b0;
         ctrl.jalr      = 1'b0;
         ctrl.branch    = 1'b0;
      end
      ctrl.illegal = ~legal;
      is_div       = div_raw & legal;
   end

endmodule

// File: rtl/decode_ctrl_stage.sv
// RV32 decode/control stage: decodes instr_d and registers the controls into
// the ID/EX boundary, with stall/flush handling, a multi-cycle divide hold
// and a saturating illegal-instruction counter.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   instr_d, valid_d    - instruction in D and its valid flag
//   stall_e, flush_e    - hazard unit hold / bubble requests for E
//   valid_e ... funct3_e, illegal_e - registered E controls
//   md_busy             - divide occupying E; hazard unit stalls F/D/E
//   illegal_count       - saturating count of illegal instructions loaded
module decode_ctrl_stage
   import decode_ctrl_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b1,
   parameter int DIV_CYCLES = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr_d,
   input  logic             valid_d,
   input  logic             stall_e,
   input  logic             flush_e,
   output logic             valid_e,
   output logic             reg_write_e,
   output logic [2:0]       imm_src_e,
   output logic             alu_src_e,
   output logic             mem_write_e,
   output logic [1:0]       result_src_e,
   output logic [3:0]       alu_ctrl_e,
   output logic             jump_e,
   output logic             jalr_e,
   output logic             branch_e,
   output logic [2:0]       funct3_e,
   output logic             illegal_e,
   output logic             md_busy,
   output logic [CNT_W-1:0] illegal_count
);

   localparam int             DIV_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV_CYCLES - 1);

   ctrl_t             dec_ctrl;
   logic              dec_is_div;

   ctrl_t             ctrl_e_d,      ctrl_e_q;
   logic              valid_e_d,     valid_e_q;
   logic [DIV_W-1:0]  div_cnt_d,     div_cnt_q;
   logic [CNT_W-1:0]  illegal_cnt_d, illegal_cnt_q;
   div_state_t        div_state;
   logic              load_e;

   decode_ctrl_comb #(
      .ENABLE_M (ENABLE_M)
   ) u_dec (
      .instr  (instr_d),
      .ctrl   (dec_ctrl),
      .is_div (dec_is_div)
   );

   // The divide FSM state is encoded in the countdown register itself.
   assign div_state = (div_cnt_q != '0) ? DIV_BUSY : DIV_IDLE;
   assign md_busy   = (div_state == DIV_BUSY);

   always_comb begin
      ctrl_e_d      = ctrl_e_q;
      valid_e_d     = valid_e_q;
      div_cnt_d     = div_cnt_q;
      illegal_cnt_d = illegal_cnt_q;
      load_e        = 1'b0;

      if (flush_e) begin
         ctrl_e_d  = '0;
         valid_e_d = 1'b0;
         div_cnt_d = '0;
      end else begin
         // The countdown runs regardless of stall_e.
         if (div_state == DIV_BUSY) div_cnt_d = div_cnt_q - DIV_W'(1);
         load_e = ~stall_e & (div_state == DIV_IDLE);
      end

      if (load_e) begin
         valid_e_d = valid_d;
         ctrl_e_d  = valid_d ? dec_ctrl : '0;
         if (valid_d && dec_is_div) div_cnt_d = DIV_LOAD;
         if (valid_d && dec_ctrl.illegal && illegal_cnt_q != '1)
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every flop samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_e_q      <= '0;
         valid_e_q     <= 1'b0;
         div_cnt_q     <= '0;
         illegal_cnt_q <= '0;
      end else begin
         ctrl_e_q      <= ctrl_e_d;
         valid_e_q     <= valid_e_d;
         div_cnt_q     <= div_cnt_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign valid_e       = valid_e_q;
   assign reg_write_e   = ctrl_e_q.reg_write;
   assign imm_src_e     = ctrl_e_q.imm_src;
   assign alu_src_e     = ctrl_e_q.alu_src;
   assign mem_write_e   = ctrl_e_q.mem_write;
   assign result_src_e  = ctrl_e_q.result_src;
   assign alu_ctrl_e    = ctrl_e_q.alu_ctrl;
   assign jump_e        = ctrl_e_q.jump;
   assign jalr_e        = ctrl_e_q.jalr;
   assign branch_e      = ctrl_e_q.branch;
   assign funct3_e      = ctrl_e_q.funct3;
   assign illegal_e     = ctrl_e_q.illegal;
   assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage. Two instances share the stimulus:
// dut_m (ENABLE_M=1, CNT_W=16) and dut_nm (ENABLE_M=0, CNT_W=2). A driver
// applies inputs on the falling edge and pushes the reference model's
// prediction for the next E state; a monitor pops and compares after each
// rising edge. On illegal instructions only the architecturally defined
// fields are compared (imm_src/alu_src/result_src/alu_ctrl are don't-care).
module tb_decode_ctrl_stage;

   localparam int DIV_CYCLES = 8;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [2:0]  imm_src;
      logic        alu_src;
      logic        mem_write;
      logic [1:0]  result_src;
      logic [3:0]  alu_ctrl;
      logic        jump;
      logic        jalr;
      logic        branch;
      logic [2:0]  funct3;
      logic        illegal;
      logic        md_busy;
      logic [15:0] cnt;
   } obs_t;

   logic        clk;
   logic        reset;
   logic [31:0] instr_d;
   logic        valid_d;
   logic        stall_e;
   logic        flush_e;

   // dut_m outputs
   logic        valid_e_m, reg_write_e_m, alu_src_e_m, mem_write_e_m;
   logic [2:0]  imm_src_e_m, funct3_e_m;
   logic [1:0]  result_src_e_m;
   logic [3:0]  alu_ctrl_e_m;
   logic        jump_e_m, jalr_e_m, branch_e_m, illegal_e_m, md_busy_m;
   logic [15:0] illegal_count_m;
   // dut_nm outputs
   logic        valid_e_n, reg_write_e_n, alu_src_e_n, mem_write_e_n;
   logic [2:0]  imm_src_e_n, funct3_e_n;
   logic [1:0]  result_src_e_n;
   logic [3:0]  alu_ctrl_e_n;
   logic        jump_e_n, jalr_e_n, branch_e_n, illegal_e_n, md_busy_n;
   logic [1:0]  illegal_count_n;

   decode_ctrl_stage #(.ENABLE_M(1'b1), .DIV_CYCLES(DIV_CYCLES), .CNT_W(16)) dut_m (
      .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
      .stall_e(stall_e), .flush_e(flush_e),
      .valid_e(valid_e_m), .reg_write_e(reg_write_e_m), .imm_src_e(imm_src_e_m),
      .alu_src_e(alu_src_e_m), .mem_write_e(mem_write_e_m),
      .result_src_e(result_src_e_m), .alu_ctrl_e(alu_ctrl_e_m),
      .jump_e(jump_e_m), .jalr_e(jalr_e_m), .branch_e(branch_e_m),
      .funct3_e(funct3_e_m), .illegal_e(illegal_e_m), .md_busy(md_busy_m),
      .illegal_count(illegal_count_m)
   );

   decode_ctrl_stage #(.ENABLE_M(1'b0), .DIV_CYCLES(DIV_CYCLES), .CNT_W(2)) dut_nm (
      .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
      .stall_e(stall_e), .flush_e(flush_e),
      .valid_e(valid_e_n), .reg_write_e(reg_write_e_n), .imm_src_e(imm_src_e_n),
      .alu_src_e(alu_src_e_n), .mem_write_e(mem_write_e_n),
      .result_src_e(result_src_e_n), .alu_ctrl_e(alu_ctrl_e_n),
      .jump_e(jump_e_n), .jalr_e(jalr_e_n), .branch_e(branch_e_n),
      .funct3_e(funct3_e_n), .illegal_e(illegal_e_n), .md_busy(md_busy_n),
      .illegal_count(illegal_count_n)
   );

   obs_t act_m, act_n;
   assign act_m = {valid_e_m, reg_write_e_m, imm_src_e_m, alu_src_e_m, mem_write_e_m,
                   result_src_e_m, alu_ctrl_e_m, jump_e_m, jalr_e_m, branch_e_m,
                   funct3_e_m, illegal_e_m, md_busy_m, illegal_count_m};
   assign act_n = {valid_e_n, reg_write_e_n, imm_src_e_n, alu_src_e_n, mem_write_e_n,
                   result_src_e_n, alu_ctrl_e_n, jump_e_n, jalr_e_n, branch_e_n,
                   funct3_e_n, illegal_e_n, md_busy_n, 14'd0, illegal_count_n};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   obs_t q_m[$];
   obs_t q_n[$];

   // ---------------- reference model ----------------
   obs_t m_e[2];      // E contents (valid + controls)
   int   m_occ[2];    // cycles the current divide still occupies E, incl. this one
   int   m_cnt[2];    // illegal counter

   // Spec-level decode: returns E contents for a valid instruction.
   function automatic obs_t ref_decode(input logic [31:0] ins, input bit en_m,
                                       output bit is_div);
      obs_t       d;
      logic [6:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      bit         ok;
      int         base_tbl[8];
      base_tbl = '{0, 7, 5, 6, 4, 8, 3, 2};  // add sll slt sltu xor srl or and
      d      = '0;
      op     = ins[6:0];
      f3     = ins[14:12];
      f7     = ins[31:25];
      is_div = 1'b0;
      ok     = (ins[1:0] == 2'b11);
      d.valid  = 1'b1;
      d.funct3 = f3;
      case (op)
         7'h03: begin d.reg_write = 1; d.alu_src = 1; d.result_src = 2'd1;
                      if (f3 == 3 || f3 == 6 || f3 == 7) ok = 0; end
         7'h23: begin d.mem_write = 1; d.imm_src = 3'd1; d.alu_src = 1;
                      if (f3 > 2) ok = 0; end
         7'h33: begin
            d.reg_write = 1;
            if (f7 == 7'h00)                  d.alu_ctrl = 4'(base_tbl[f3]);
            else if (f7 == 7'h20 && f3 == 0)  d.alu_ctrl = 4'd1;
            else if (f7 == 7'h20 && f3 == 5)  d.alu_ctrl = 4'd9;
            else if (f7 == 7'h01 && en_m) begin
               if (f3 >= 4) begin d.alu_ctrl = 4'd14; is_div = 1'b1; end
               else d.alu_ctrl = 4'(10 + int'(f3));
            end else ok = 0;
         end
         7'h13: begin
            d.reg_write = 1; d.alu_src = 1; d.alu_ctrl = 4'(base_tbl[f3]);
            if (f3 == 1 && f7 != 0) ok = 0;
            if (f3 == 5) begin
               if (f7 == 7'h20) d.alu_ctrl = 4'd9;
               else if (f7 != 0) ok = 0;
            end
         end
         7'h63: begin d.branch = 1; d.imm_src = 3'd2; d.alu_ctrl = 4'd1;
                      if (f3 == 2 || f3 == 3) ok = 0; end
         7'h17: begin d.reg_write = 1; d.imm_src = 3'd4; d.alu_src = 1; d.result_src = 2'd3; end
         7'h37: begin d.reg_write = 1; d.imm_src = 3'd5; d.alu_src = 1; d.result_src = 2'd3;
                      d.alu_ctrl = 4'd15; end
         7'h67: begin d.reg_write = 1; d.alu_src = 1; d.result_src = 2'd2; d.jalr = 1;
                      if (f3 != 0) ok = 0; end
         7'h6f: begin d.reg_write = 1; d.imm_src = 3'd3; d.result_src = 2'd2; d.jump = 1; end
         default: ok = 0;
      endcase
      if (!ok) begin
         d.reg_write = 0; d.mem_write = 0; d.jump = 0; d.jalr = 0; d.branch = 0;
         is_div = 1'b0;
      end
      d.illegal = !ok;
      return d;
   endfunction

   // Advance model k by one clock edge and return the expected outputs.
   function automatic obs_t model_step(input int k, input logic [31:0] ins,
                                       input bit vd, input bit st, input bit fl,
                                       input bit rs);
      obs_t exp;
      obs_t dec;
      bit   is_div;
      bit   busy;
      int   cnt_max;
      cnt_max = (k == 0) ? 65535 : 3;
      busy    = (m_occ[k] > 1);
      dec     = ref_decode(ins, (k == 0), is_div);
      if (rs) begin
         m_e[k] = '0; m_occ[k] = 0; m_cnt[k] = 0;
      end else if (fl) begin
         m_e[k] = '0; m_occ[k] = 0;
      end else begin
         if (m_occ[k] > 0) m_occ[k] = m_occ[k] - 1;
         if (!st && !busy) begin
            m_e[k] = vd ? dec : '0;
            if (vd && is_div) m_occ[k] = DIV_CYCLES;
            if (vd && dec.illegal && m_cnt[k] < cnt_max) m_cnt[k] = m_cnt[k] + 1;
         end
      end
      exp         = m_e[k];
      exp.md_busy = (m_occ[k] > 1);
      exp.cnt     = 16'(m_cnt[k]);
      return exp;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input obs_t exp, input obs_t act);
      obs_t mask;
      mask = '1;
      if (exp.valid && exp.illegal) begin
         mask.imm_src = '0; mask.alu_src = '0; mask.result_src = '0; mask.alu_ctrl = '0;
      end
      checks++;
      if (((exp ^ act) & mask) !== '0) begin
         errors++;
         $display("FAIL %s: got %h expected %h (care mask %h)", name, act, exp, mask);
      end
   endtask

   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (q_m.size() > 0) begin
            e = q_m.pop_front();
            check($sformatf("dut_m cyc%0d", cycle), e, act_m);
         end
         if (q_n.size() > 0) begin
            e = q_n.pop_front();
            check($sformatf("dut_nm cyc%0d", cycle), e, act_n);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [31:0] ins, input bit vd, input bit st,
                        input bit fl, input bit rs);
      @(negedge clk);
      instr_d = ins;
      valid_d = vd;
      stall_e = st;
      flush_e = fl;
      reset   = rs;
      q_m.push_back(model_step(0, ins, vd, st, fl, rs));
      q_n.push_back(model_step(1, ins, vd, st, fl, rs));
   endtask

   localparam logic [31:0] I_LW    = 32'h00412083;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRA   = 32'h4020D1B3;
   localparam logic [31:0] I_BAD7  = 32'h4020F1B3;
   localparam logic [31:0] I_DIV   = 32'h0220C1B3;
   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_ILLOP = 32'h0000007F;

   initial begin
      logic [6:0] ops[9];
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h17, 7'h37, 7'h67, 7'h6f};
      for (int k = 0; k < 2; k++) begin
         m_e[k] = '0; m_occ[k] = 0; m_cnt[k] = 0;
      end
      reset = 1'b1; instr_d = '0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;

      drive(32'h0, 0, 0, 0, 1);
      drive(32'h0, 0, 0, 0, 1);

      // Basic decode: lw, sub, sra, illegal funct7/funct3 combination
      drive(I_LW,   1, 0, 0, 0);
      drive(I_SUB,  1, 0, 0, 0);
      drive(I_SRA,  1, 0, 0, 0);
      drive(I_BAD7, 1, 0, 0, 0);
      drive(I_ADD,  0, 0, 0, 0);

      // Divide hold (dut_m) vs illegal divide (dut_nm)
      drive(I_DIV, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(I_ADD, 1, 0, 0, 0);

      // Divide flushed mid-countdown, then a normal load
      drive(I_DIV, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(I_ADD, 1, 0, 0, 0);
      drive(I_ADD, 1, 0, 1, 0);
      drive(I_LW,  1, 0, 0, 0);

      // Illegal opcode held in D by stall, then loads once
      for (int i = 0; i < 3; i++) drive(I_ILLOP, 1, 1, 0, 0);
      drive(I_ILLOP, 1, 0, 0, 0);
      // Saturation of the 2-bit counter in dut_nm
      for (int i = 0; i < 5; i++) drive(I_ILLOP, 1, 0, 0, 0);

      // Reset mid-divide with flush and stall also asserted
      drive(I_DIV, 1, 0, 0, 0);
      drive(I_ADD, 1, 0, 0, 0);
      drive(I_ADD, 1, 0, 0, 0);
      drive(I_ADD, 1, 1, 1, 1);
      drive(I_SUB, 1, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         int          sel;
         ins = $urandom;
         sel = $urandom_range(0, 11);
         if (sel < 9) ins[6:0] = ops[sel];
         case ($urandom_range(0, 3))
            0:       ins[31:25] = 7'h00;
            1:       ins[31:25] = 7'h20;
            2:       ins[31:25] = 7'h01;
            default: ;
         endcase
         drive(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
               $urandom_range(0, 11) == 0, $urandom_range(0, 99) == 0);
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q_m.size() != 0 || q_n.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expectations, required 0/0",
                  q_m.size(), q_n.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
